// File: rtl/delay_ctrl.sv
// Block-framed sequencer for the encoder delay FIFO: gates write/read enables so
// every symbol leaves the FIFO exactly delay_len accepted symbols after it entered.
module delay_ctrl #(
    parameter int CW         = 13,
    parameter int FIFO_DEPTH = 6144
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          start,
    input  logic [CW-1:0] block_len,
    input  logic [CW-1:0] delay_len,
    input  logic          abort,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          fifo_full,
    input  logic          fifo_empty,
    output logic          fifo_we,
    output logic          fifo_re,
    output logic          fifo_clr,
    output logic          out_valid,
    output logic          busy,
    output logic          done,
    output logic          err_cfg
);

    typedef enum logic [2:0] {
        IDLE,
        FILL,
        STREAM,
        DRAIN,
        DONE
    } state_t;

    localparam logic [CW-1:0] DEPTH_LIMIT = CW'(FIFO_DEPTH);

    state_t        state;
    state_t        state_next;
    logic [CW-1:0] blk;
    logic [CW-1:0] dly;
    logic [CW-1:0] wr_cnt;
    logic [CW-1:0] rd_cnt;
    logic [CW-1:0] wr_inc;
    logic [CW-1:0] rd_inc;
    logic          cfg_bad;
    logic          start_ok;
    logic          abort_hit;

    assign wr_inc    = wr_cnt + CW'(1);
    assign rd_inc    = rd_cnt + CW'(1);
    assign cfg_bad   = (block_len == '0) || (delay_len > DEPTH_LIMIT);
    assign start_ok  = (state == IDLE) && start && !cfg_bad;
    assign abort_hit = abort && (state != IDLE);

    assign busy = (state != IDLE);
    assign done = (state == DONE);

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        fifo_we    = 1'b0;
        fifo_re    = 1'b0;

        case (state)
            IDLE: begin
                if (start_ok) begin
                    state_next = (delay_len != '0) ? FILL : STREAM;
                end
            end

            // A block shorter than its delay leaves FILL on the last write instead of stalling.
            FILL: begin
                in_ready = (wr_cnt < blk) && !fifo_full;
                fifo_we  = in_valid && in_ready;
                if (fifo_we && ((wr_inc == dly) || (wr_inc == blk))) begin
                    state_next = (wr_inc == blk) ? DRAIN : STREAM;
                end
            end

            // Every write is paired with a read, so a full FIFO cannot overflow here.
            STREAM: begin
                in_ready = (wr_cnt < blk);
                fifo_we  = in_valid && in_ready;
                fifo_re  = fifo_we;
                if (fifo_we && (wr_inc == blk)) begin
                    state_next = (rd_inc == blk) ? DONE : DRAIN;
                end
            end

            DRAIN: begin
                fifo_re = !fifo_empty && (rd_cnt < blk);
                if (fifo_re && (rd_inc == blk)) begin
                    state_next = DONE;
                end
            end

            DONE: begin
                state_next = IDLE;
            end

            default: begin
                state_next = IDLE;
            end
        endcase

        if (abort_hit) begin
            state_next = IDLE;
        end
    end

    // A read issued in the abort cycle never reports valid data; the FIFO is being cleared.
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            blk       <= '0;
            dly       <= '0;
            wr_cnt    <= '0;
            rd_cnt    <= '0;
            out_valid <= 1'b0;
            fifo_clr  <= 1'b0;
            err_cfg   <= 1'b0;
        end else begin
            state     <= state_next;
            out_valid <= fifo_re && !abort_hit;
            fifo_clr  <= abort_hit;
            err_cfg   <= (state == IDLE) && start && cfg_bad;

            if (abort_hit) begin
                wr_cnt <= '0;
                rd_cnt <= '0;
            end else if (start_ok) begin
                blk    <= block_len;
                dly    <= delay_len;
                wr_cnt <= '0;
                rd_cnt <= '0;
            end else begin
                if (fifo_we) begin
                    wr_cnt <= wr_inc;
                end
                if (fifo_re) begin
                    rd_cnt <= rd_inc;
                end
            end
        end
    end

endmodule

// File: tb/tb_delay_ctrl.sv
// Directed bench for delay_ctrl: per-cycle expected enables/status are queued with
// each stimulus step and compared against the DUT half a cycle later.
module tb_delay_ctrl;

    localparam int CW         = 13;
    localparam int FIFO_DEPTH = 6144;

    logic          clock = 1'b0;
    logic          reset;
    logic          start;
    logic [CW-1:0] block_len;
    logic [CW-1:0] delay_len;
    logic          abort;
    logic          in_valid;
    logic          in_ready;
    logic          fifo_full;
    logic          fifo_empty;
    logic          fifo_we;
    logic          fifo_re;
    logic          fifo_clr;
    logic          out_valid;
    logic          busy;
    logic          done;
    logic          err_cfg;

    delay_ctrl #(.CW(CW), .FIFO_DEPTH(FIFO_DEPTH)) dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .block_len  (block_len),
        .delay_len  (delay_len),
        .abort      (abort),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .fifo_full  (fifo_full),
        .fifo_empty (fifo_empty),
        .fifo_we    (fifo_we),
        .fifo_re    (fifo_re),
        .fifo_clr   (fifo_clr),
        .out_valid  (out_valid),
        .busy       (busy),
        .done       (done),
        .err_cfg    (err_cfg)
    );

    always #5 clock = ~clock;

    // Occupancy model of the external FIFO; force_full lets a step fake a full flag.
    int   occ = 0;
    logic force_full = 1'b0;
    assign fifo_full  = force_full || (occ >= FIFO_DEPTH);
    assign fifo_empty = (occ == 0);

    always @(posedge clock) begin
        if (reset || fifo_clr) occ <= 0;
        else                   occ <= occ + int'(fifo_we) - int'(fifo_re);
    end

    typedef struct {
        logic          rst;
        logic          s;
        logic          iv;
        logic          ab;
        logic          ff;
        logic [CW-1:0] bl;
        logic [CW-1:0] dl;
    } stim_t;

    // bits = {in_ready, fifo_we, fifo_re, out_valid, done, busy, fifo_clr, err_cfg}
    typedef struct {
        string      tag;
        logic [7:0] bits;
    } exp_t;

    exp_t  sb[$];
    int    checks   = 0;
    int    failures = 0;
    int    n_we     = 0;
    int    n_ov     = 0;
    string names[8] = '{"rdy", "we", "re", "ov", "done", "busy", "clr", "err"};

    function automatic stim_t mk(logic rst, logic s, logic iv, logic ab, logic ff,
                                 logic [CW-1:0] bl, logic [CW-1:0] dl);
        stim_t st;
        st.rst = rst; st.s = s; st.iv = iv; st.ab = ab; st.ff = ff;
        st.bl  = bl;  st.dl = dl;
        return st;
    endfunction

    task automatic compare_bit(string tag, logic obs, logic expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("[TB] FAIL %s observed=%b expected=%b", tag, obs, expv);
        end
    endtask

    task automatic compare_int(string tag, int obs, int expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic apply_stimulus(stim_t st, string tag, logic [7:0] bits);
        exp_t e;
        @(negedge clock);
        reset      = st.rst;
        start      = st.s;
        in_valid   = st.iv;
        abort      = st.ab;
        force_full = st.ff;
        block_len  = st.bl;
        delay_len  = st.dl;
        e.tag  = tag;
        e.bits = bits;
        sb.push_back(e);
    endtask

    task automatic check_output();
        exp_t       e;
        logic [7:0] obs;
        #1;
        if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL scoreboard_empty observed=0 entries expected=1");
            return;
        end
        e   = sb.pop_front();
        obs = {in_ready, fifo_we, fifo_re, out_valid, done, busy, fifo_clr, err_cfg};
        n_we += int'(fifo_we);
        n_ov += int'(out_valid);
        for (int i = 7; i >= 0; i--) begin
            compare_bit({e.tag, ".", names[7-i]}, obs[i], e.bits[i]);
        end
    endtask

    task automatic step(stim_t st, string tag, logic [7:0] bits);
        apply_stimulus(st, tag, bits);
        check_output();
    endtask

    // in_valid held high: writes k=1..blk, reads k=dly+1..blk+dly, done at blk+dly+1.
    task automatic run_simple(string tag, int blk, int dly, bit busy_start,
                              bit start_abort, int abort_at, int reset_at);
        stim_t      st;
        logic [7:0] b;
        logic       mid;
        st = mk(0, 1, 0, start_abort, 0, CW'(blk), CW'(dly));
        step(st, {tag, ".start"}, 8'h00);
        for (int k = 1; k <= blk + dly + 2; k++) begin
            b = {(k <= blk), (k <= blk), (k > dly && k <= blk + dly),
                 (k > dly + 1 && k <= blk + dly + 1), (k == blk + dly + 1),
                 (k <= blk + dly + 1), 1'b0, 1'b0};
            mid = busy_start && (k == 2);
            st  = mk(k == reset_at, mid, 1, k == abort_at, 0,
                     mid ? CW'(2) : CW'(0), mid ? CW'(1) : CW'(0));
            step(st, $sformatf("%s.k%0d", tag, k), b);
            if (k == abort_at) begin
                step(mk(0, 0, 1, 0, 0, 0, 0), {tag, ".abort_next"}, 8'b0000_0010);
                step(mk(0, 0, 1, 0, 0, 0, 0), {tag, ".abort_idle"}, 8'h00);
                return;
            end
            if (k == reset_at) begin
                step(mk(0, 0, 1, 0, 0, 0, 0), {tag, ".reset_next"}, 8'h00);
                return;
            end
        end
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog observed=timeout expected=completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        stim_t      idle;
        logic [7:0] b;
        logic       prev_re;
        logic       re_k;

        reset = 1'b1; start = 1'b0; abort = 1'b0; in_valid = 1'b0;
        block_len = '0; delay_len = '0;
        idle = mk(0, 0, 0, 0, 0, 0, 0);
        repeat (3) @(posedge clock);

        step(idle, "reset", 8'h00);
        step(mk(0, 0, 1, 1, 0, 0, 0), "idle_abort", 8'h00);
        step(idle, "idle_abort.next", 8'h00);

        run_simple("t1_b8d3", 8, 3, 1, 0, 0, 0);
        run_simple("t2_b4d0", 4, 0, 0, 1, 0, 0);
        run_simple("t3_b5d5", 5, 5, 0, 0, 0, 0);

        // blk=16 dly=4 with in_valid on odd cycles only
        step(mk(0, 1, 0, 0, 0, 16, 4), "t4.start", 8'h00);
        n_we = 0; n_ov = 0; prev_re = 1'b0;
        for (int k = 1; k <= 37; k++) begin
            if (k <= 31) begin
                re_k = (k % 2 == 1) && (k >= 9);
                b = {1'b1, (k % 2 == 1), re_k, prev_re, 1'b0, 1'b1, 2'b00};
            end else if (k <= 35) begin
                re_k = 1'b1;
                b = {2'b00, re_k, prev_re, 1'b0, 1'b1, 2'b00};
            end else begin
                re_k = 1'b0;
                b = {3'b000, prev_re, (k == 36), (k == 36), 2'b00};
            end
            step(mk(0, 0, k % 2 == 1, 0, 0, 0, 0), $sformatf("t4.k%0d", k), b);
            prev_re = re_k;
        end
        compare_int("t4.total_we", n_we, 16);
        compare_int("t4.total_ov", n_ov, 16);

        run_simple("t5_abort", 10, 2, 0, 0, 7, 0);
        run_simple("t5_after", 2, 1, 0, 0, 0, 0);

        step(mk(0, 1, 0, 0, 0, 4, 6145), "err_dly.start", 8'h00);
        step(idle, "err_dly.pulse", 8'b0000_0001);
        step(idle, "err_dly.after", 8'h00);
        step(mk(0, 1, 0, 0, 0, 0, 2), "err_blk.start", 8'h00);
        step(idle, "err_blk.pulse", 8'b0000_0001);
        step(idle, "err_blk.after", 8'h00);

        step(mk(0, 1, 0, 0, 0, 6144, 6144), "max_dly.start", 8'h00);
        step(idle, "max_dly.k1", 8'b1000_0100);
        step(mk(0, 0, 0, 1, 0, 0, 0), "max_dly.abort", 8'b1000_0100);
        step(idle, "max_dly.clr", 8'b0000_0010);
        step(idle, "max_dly.idle", 8'h00);

        // fifo_full stalls FILL but is ignored in STREAM
        step(mk(0, 1, 0, 0, 0, 3, 1), "full.start", 8'h00);
        step(mk(0, 0, 1, 0, 1, 0, 0), "full.k1", 8'b0000_0100);
        step(mk(0, 0, 1, 0, 0, 0, 0), "full.k2", 8'b1100_0100);
        step(mk(0, 0, 1, 0, 1, 0, 0), "full.k3", 8'b1110_0100);
        step(mk(0, 0, 1, 0, 1, 0, 0), "full.k4", 8'b1111_0100);
        step(mk(0, 0, 1, 0, 0, 0, 0), "full.k5", 8'b0011_0100);
        step(mk(0, 0, 1, 0, 0, 0, 0), "full.k6", 8'b0001_1100);
        step(mk(0, 0, 1, 0, 0, 0, 0), "full.k7", 8'h00);

        run_simple("t7_reset", 8, 3, 0, 0, 0, 10);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/delay_ctrl.md
Name: delay_ctrl

Overview:
Sequencer for the encoder delay FIFO (6144-deep, falling-edge clocked). Accepts one block of block_len symbols from upstream and gates FIFO write/read enables so that each output symbol leaves exactly delay_len accepted symbols after it entered. At end of block it drains the FIFO and reports done. It sits between the upstream symbol source and the delay FIFO, replacing free-running write-enable control for block-framed traffic.

Parameters:
CW, 13, width of length/counter fields
FIFO_DEPTH, 6144, FIFO capacity; upper bound for delay_len

Ports:
clock  in  1  system clock; all state updates on rising edge
reset  in  1  synchronous, active-high reset
start  in  1  pulse: latch block_len/delay_len and begin a block; ignored while busy
block_len  in  CW  symbols in the block, sampled on accepted start
delay_len  in  CW  delay in symbols, sampled on accepted start
abort  in  1  abandon current block
in_valid  in  1  upstream symbol present
in_ready  out  1  controller will accept symbol this cycle
fifo_full  in  1  FIFO full flag
fifo_empty  in  1  FIFO empty flag
fifo_we  out  1  FIFO write enable
fifo_re  out  1  FIFO read enable
fifo_clr  out  1  one-cycle FIFO clear request
out_valid  out  1  FIFO data_out valid this cycle
busy  out  1  block in progress
done  out  1  one-cycle end-of-block pulse
err_cfg  out  1  one-cycle pulse: start rejected for bad config

Behaviour:
- Reset: state IDLE; wr_cnt=rd_cnt=0; in_ready, fifo_we, fifo_re, fifo_clr, out_valid, busy, done, err_cfg all 0. Reset wins over every other input, including mid-block.
- States: IDLE, FILL, STREAM, DRAIN, DONE.
- IDLE:
  - start with block_len==0 or delay_len>FIFO_DEPTH: err_cfg=1 next cycle, stay IDLE.
  - Otherwise, start latches lengths and clears counters. Next state is FILL if delay_len>0, else STREAM.
- Combinational handshake:
  - in_ready = (FILL or STREAM) and wr_cnt<blk and not fifo_full.
  - fifo_we = in_valid and in_ready.
- FILL: write only. wr_cnt increments per fifo_we.
  - When the write making wr_cnt==dly is accepted: go to STREAM, or to DRAIN if wr_cnt==blk.
- STREAM: fifo_re = fifo_we (one in, one out; occupancy held at dly).
  - In STREAM, in_ready additionally ignores fifo_full, because a simultaneous read occurs.
  - rd_cnt increments per fifo_re. After the write making wr_cnt==blk, go to DRAIN.
- DRAIN: fifo_re = not fifo_empty and rd_cnt<blk; in_ready=0.
  - After the read making rd_cnt==blk, go to DONE.
  - If that read occurred in STREAM (dly==0), go directly from STREAM to DONE.
- DONE: done=1 for one cycle, then IDLE.
- Read latency:
  - out_valid is fifo_re registered one cycle.
  - The final out_valid coincides with the done cycle.
- busy = state not IDLE.
- Abort in any non-IDLE state:
  - Next cycle: IDLE with fifo_clr=1 for one cycle; counters cleared; no done.
  - Pending out_valid for a read issued in the abort cycle is suppressed.
  - Abort in IDLE has no effect.
- Simultaneous start and abort in IDLE: start is processed and abort is ignored.
- Counters are CW bits and never wrap. Comparisons are unsigned against latched values.
- start while busy: ignored, no error.

Test Plan:
- blk=8, dly=3, in_valid held high -> cycles 1-3: fifo_we only. Cycles 4-8: fifo_we and fifo_re. Then 3 DRAIN reads. 8 out_valid pulses total; done on the last one.
- blk=4, dly=0 -> fifo_we=fifo_re on each of 4 cycles; no FILL or DRAIN reads; done the cycle after the 4th read.
- blk=5, dly=5 -> 5 writes, then 5 DRAIN reads; fifo_re never high during writes.
- blk=16, dly=4, in_valid toggling 1/0 -> fifo_we and fifo_re only on in_valid=1 cycles after FILL; exactly 16 writes and 16 out_valid.
- Abort in STREAM after wr_cnt=6 (blk=10, dly=2) -> fifo_clr pulse, IDLE, no done. A following start with blk=2, dly=1 completes normally.
- start with delay_len=6145 -> err_cfg pulse, busy stays 0. Reset asserted mid-DRAIN -> all outputs 0 next cycle.
